// File: rtl/ad9643_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ad9643_pkg
// Description : Shared test-mode/format encodings, pattern constants and
//               LFSR taps for the AD9643 output-stage model.
// Revision    : 1.0 - initial release
// ============================================================================
package ad9643_pkg;

    localparam int c_DATA_W = 14;

    typedef enum logic [3:0] {
        MODE_OFF      = 4'b0000,
        MODE_MIDSCALE = 4'b0001,
        MODE_POS_FS   = 4'b0010,
        MODE_NEG_FS   = 4'b0011,
        MODE_CHECKER  = 4'b0100,
        MODE_PN23     = 4'b0101,
        MODE_PN9      = 4'b0110,
        MODE_TOGGLE   = 4'b0111,
        MODE_USER     = 4'b1000,
        MODE_RAMP     = 4'b1111
    } test_mode_e;

    typedef enum logic [1:0] {
        FMT_OFFSET = 2'b00,
        FMT_TWOS   = 2'b01,
        FMT_GRAY   = 2'b10,
        FMT_RSVD   = 2'b11
    } data_format_e;

    localparam logic [c_DATA_W-1:0] c_MIDSCALE  = 14'h2000;
    localparam logic [c_DATA_W-1:0] c_POS_FS    = 14'h3FFF;
    localparam logic [c_DATA_W-1:0] c_NEG_FS    = 14'h0000;
    localparam logic [c_DATA_W-1:0] c_CHECKER_A = 14'h2AAA;
    localparam logic [c_DATA_W-1:0] c_CHECKER_B = 14'h1555;

    localparam int c_PN9_W       = 9;
    localparam int c_PN9_TAP_HI  = 8;
    localparam int c_PN9_TAP_LO  = 4;
    localparam int c_PN23_W      = 23;
    localparam int c_PN23_TAP_HI = 22;
    localparam int c_PN23_TAP_LO = 17;

    // Format conversion from offset binary; the reserved code falls back to offset binary.
    function automatic logic [c_DATA_W-1:0] format_sample(
        input logic [c_DATA_W-1:0] b,
        input logic [1:0]          fmt
    );
        case (fmt)
            FMT_TWOS: return {~b[c_DATA_W-1], b[c_DATA_W-2:0]};
            FMT_GRAY: return b ^ (b >> 1);
            default:  return b;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/ad9643_lfsr.sv
`default_nettype none
// ============================================================================
// Module      : ad9643_lfsr
// Description : Fibonacci LFSR, shift-left with two-tap feedback into bit 0.
// Revision    : 1.0 - initial release
// ============================================================================
module ad9643_lfsr #(
    parameter int               WIDTH  = 9,
    parameter int               TAP_HI = 8,
    parameter int               TAP_LO = 4,
    parameter logic [WIDTH-1:0] SEED   = '1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             advance,
    output logic [WIDTH-1:0] state
);

    logic [WIDTH-1:0] r_state;

    function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] s);
        return {s[WIDTH-2:0], s[TAP_HI] ^ s[TAP_LO]};
    endfunction

    // Load jumps straight past the seed, since the seed itself is emitted on the load cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= SEED;
        end else if (load) begin
            r_state <= lfsr_next(SEED);
        end else if (advance) begin
            r_state <= lfsr_next(r_state);
        end
    end

    assign state = r_state;

endmodule
`default_nettype wire

// File: rtl/ad9643_test_pattern_mux.sv
`default_nettype none
// ============================================================================
// Module      : ad9643_test_pattern_mux
// Description : Selects live ADC data or a built-in test pattern, applies the
//               output data format and registers the result.
// Revision    : 1.0 - initial release
// ============================================================================
module ad9643_test_pattern_mux
    import ad9643_pkg::*;
#(
    parameter int          DATA_W    = c_DATA_W,
    parameter logic [8:0]  PN9_SEED  = 9'h1FF,
    parameter logic [22:0] PN23_SEED = 23'h7FFFFF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        select_mode,
    input  logic [DATA_W-1:0] adc_data,
    input  logic [15:0]       user_pattern,
    input  logic [1:0]        data_format,
    output logic [DATA_W-1:0] out_data,
    output logic              pattern_active
);

    logic [3:0]        r_mode_q;
    logic [DATA_W-1:0] r_ramp;
    logic              r_checker_phase;
    logic              r_toggle_phase;
    logic [DATA_W-1:0] r_out_data;
    logic              r_pattern_active;

    logic              w_mode_change;
    logic [DATA_W-1:0] w_ramp_src;
    logic              w_checker_src;
    logic              w_toggle_src;
    logic [8:0]        w_pn9_state;
    logic [22:0]       w_pn23_state;
    logic [8:0]        w_pn9_src;
    logic [22:0]       w_pn23_src;
    logic [DATA_W-1:0] w_raw;
    logic              w_active;
    logic              w_pn9_sel;
    logic              w_pn23_sel;

    // A mode change substitutes the seed for the stored state so patterns restart cleanly.
    assign w_mode_change = (select_mode != r_mode_q);
    assign w_ramp_src    = w_mode_change ? '0 : r_ramp;
    assign w_checker_src = w_mode_change ? 1'b0 : r_checker_phase;
    assign w_toggle_src  = w_mode_change ? 1'b0 : r_toggle_phase;
    assign w_pn9_src     = w_mode_change ? PN9_SEED : w_pn9_state;
    assign w_pn23_src    = w_mode_change ? PN23_SEED : w_pn23_state;

    assign w_pn9_sel  = (select_mode == MODE_PN9);
    assign w_pn23_sel = (select_mode == MODE_PN23);

    ad9643_lfsr #(
        .WIDTH  (c_PN9_W),
        .TAP_HI (c_PN9_TAP_HI),
        .TAP_LO (c_PN9_TAP_LO),
        .SEED   (PN9_SEED)
    ) u_pn9 (
        .clk     (clk),
        .reset   (reset),
        .load    (w_pn9_sel & w_mode_change),
        .advance (w_pn9_sel & ~w_mode_change),
        .state   (w_pn9_state)
    );

    ad9643_lfsr #(
        .WIDTH  (c_PN23_W),
        .TAP_HI (c_PN23_TAP_HI),
        .TAP_LO (c_PN23_TAP_LO),
        .SEED   (PN23_SEED)
    ) u_pn23 (
        .clk     (clk),
        .reset   (reset),
        .load    (w_pn23_sel & w_mode_change),
        .advance (w_pn23_sel & ~w_mode_change),
        .state   (w_pn23_state)
    );

    always_comb begin
        w_raw    = adc_data;
        w_active = 1'b1;
        case (select_mode)
            MODE_MIDSCALE: w_raw = c_MIDSCALE;
            MODE_POS_FS:   w_raw = c_POS_FS;
            MODE_NEG_FS:   w_raw = c_NEG_FS;
            MODE_CHECKER:  w_raw = w_checker_src ? c_CHECKER_B : c_CHECKER_A;
            MODE_PN23:     w_raw = w_pn23_src[22:9];
            MODE_PN9:      w_raw = {w_pn9_src, w_pn9_src[8:4]};
            MODE_TOGGLE:   w_raw = w_toggle_src ? c_NEG_FS : c_POS_FS;
            MODE_USER:     w_raw = user_pattern[15:2];
            MODE_RAMP:     w_raw = w_ramp_src;
            default: begin
                w_raw    = adc_data;
                w_active = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mode_q         <= MODE_OFF;
            r_ramp           <= '0;
            r_checker_phase  <= 1'b0;
            r_toggle_phase   <= 1'b0;
            r_out_data       <= '0;
            r_pattern_active <= 1'b0;
        end else begin
            r_mode_q         <= select_mode;
            r_out_data       <= format_sample(w_raw, data_format);
            r_pattern_active <= w_active;
            if (select_mode == MODE_RAMP) begin
                r_ramp <= w_ramp_src + DATA_W'(1);
            end
            if (select_mode == MODE_CHECKER) begin
                r_checker_phase <= ~w_checker_src;
            end
            if (select_mode == MODE_TOGGLE) begin
                r_toggle_phase <= ~w_toggle_src;
            end
        end
    end

    assign out_data       = r_out_data;
    assign pattern_active = r_pattern_active;

    logic w_unused_bits;
    assign w_unused_bits = &{1'b0, user_pattern[1:0], w_pn23_src[8:0]};

endmodule
`default_nettype wire

// File: tb/tb_ad9643_test_pattern_mux.sv
`default_nettype none
// ============================================================================
// Module      : tb_ad9643_test_pattern_mux
// Description : Directed scoreboard bench for the AD9643 test-pattern mux.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ad9643_test_pattern_mux;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  select_mode;
    logic [13:0] adc_data;
    logic [15:0] user_pattern;
    logic [1:0]  data_format;
    logic [13:0] out_data;
    logic        pattern_active;

    typedef struct {
        logic [13:0] data;
        logic        act;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    n_pass = 0;
    int    n_chk  = 0;

    ad9643_test_pattern_mux dut (
        .clk            (clk),
        .reset          (reset),
        .select_mode    (select_mode),
        .adc_data       (adc_data),
        .user_pattern   (user_pattern),
        .data_format    (data_format),
        .out_data       (out_data),
        .pattern_active (pattern_active)
    );

    always #5 clk = ~clk;

    // Expectation is queued with the stimulus, then retired one clock later.
    task automatic step(input logic [13:0] d, input logic a, input string tag);
        exp_t  e;
        exp_t  got;
        string t;
        e.data = d;
        e.act  = a;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        got = exp_q.pop_front();
        t   = tag_q.pop_front();
        n_chk++;
        assert (out_data === got.data) n_pass++;
        else $error("FAIL %s out_data observed=%h expected=%h", t, out_data, got.data);
        n_chk++;
        assert (pattern_active === got.act) n_pass++;
        else $error("FAIL %s pattern_active observed=%b expected=%b", t, pattern_active, got.act);
    endtask

    initial begin
        logic [8:0]  pn9;
        logic [22:0] pn23;

        reset        = 1'b1;
        select_mode  = 4'b0001;
        adc_data     = 14'h0000;
        user_pattern = 16'h0000;
        data_format  = 2'b01;

        repeat (3) step(14'h0000, 1'b0, "reset_hold");
        reset = 1'b0;
        step(14'h0000, 1'b1, "midscale_twos");
        data_format = 2'b00;
        step(14'h2000, 1'b1, "midscale_offset");

        select_mode = 4'b1111;
        for (int i = 0; i < 16386; i++) begin
            step(14'(i), 1'b1, "ramp");
        end
        select_mode = 4'b0100;
        step(14'h2AAA, 1'b1, "ramp_to_checker_a");
        step(14'h1555, 1'b1, "ramp_to_checker_b");
        select_mode = 4'b1111;
        step(14'h0000, 1'b1, "ramp_restart0");
        step(14'h0001, 1'b1, "ramp_restart1");

        select_mode = 4'b0110;
        step(14'h3FFF, 1'b1, "pn9_first");
        step(14'h3FDF, 1'b1, "pn9_second");
        pn9 = 9'h1FF;
        pn9 = {pn9[7:0], pn9[8] ^ pn9[4]};
        pn9 = {pn9[7:0], pn9[8] ^ pn9[4]};
        for (int i = 0; i < 20; i++) begin
            step({pn9, pn9[8:4]}, 1'b1, "pn9_run");
            pn9 = {pn9[7:0], pn9[8] ^ pn9[4]};
        end

        select_mode = 4'b0101;
        pn23 = 23'h7FFFFF;
        for (int i = 0; i < 40; i++) begin
            step(pn23[22:9], 1'b1, "pn23_run");
            pn23 = {pn23[21:0], pn23[22] ^ pn23[17]};
        end

        select_mode  = 4'b1000;
        user_pattern = 16'hABCD;
        step(14'h2AF3, 1'b1, "user_offset");
        data_format = 2'b01;
        step(14'h0AF3, 1'b1, "user_twos");
        data_format  = 2'b00;
        user_pattern = 16'h0007;
        step(14'h0001, 1'b1, "user_lsbs_dropped");

        select_mode = 4'b0000;
        adc_data    = 14'h0003;
        data_format = 2'b10;
        step(14'h0002, 1'b0, "adc_gray");
        select_mode = 4'b1010;
        step(14'h0002, 1'b0, "reserved_mode_gray");
        adc_data    = 14'h1234;
        data_format = 2'b01;
        step(14'h3234, 1'b0, "reserved_mode_twos");
        data_format = 2'b11;
        step(14'h1234, 1'b0, "adc_fmt11");

        select_mode = 4'b0010;
        data_format = 2'b10;
        step(14'h2000, 1'b1, "posfs_gray");
        select_mode = 4'b0011;
        data_format = 2'b01;
        step(14'h2000, 1'b1, "negfs_twos");
        data_format = 2'b00;

        select_mode = 4'b0111;
        step(14'h3FFF, 1'b1, "toggle0");
        step(14'h0000, 1'b1, "toggle1");
        step(14'h3FFF, 1'b1, "toggle2");
        select_mode = 4'b0100;
        step(14'h2AAA, 1'b1, "checker0");
        step(14'h1555, 1'b1, "checker1");
        step(14'h2AAA, 1'b1, "checker2");
        step(14'h1555, 1'b1, "checker3");
        reset = 1'b1;
        step(14'h0000, 1'b0, "reset_mid");
        reset = 1'b0;
        step(14'h2AAA, 1'b1, "checker_after_reset0");
        step(14'h1555, 1'b1, "checker_after_reset1");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ad9643_test_pattern_mux.md
Name: ad9643_test_pattern_mux

Overview:
Output-stage source selector and formatter for one AD9643 channel model. It sits directly downstream of the user-test-pattern FSM and consumes that FSM's 16-bit user-pattern word. It selects between live conversion data and the built-in test patterns according to select_mode, applies the output data format, and registers the 14-bit result. The result feeds the LVDS/DDR output serialiser model.

Parameters:
DATA_W, 14, output sample width in bits.
PN9_SEED, 9'h1FF, PN9 LFSR seed.
PN23_SEED, 23'h7FFFFF, PN23 LFSR seed.

Ports:
clk  in  1  sample clock; all logic uses posedge only.
reset  in  1  synchronous, active-high reset.
select_mode  in  4  test-mode code; same encoding as the user-pattern FSM (4'b1000 = user pattern).
adc_data  in  DATA_W  live conversion sample, offset binary.
user_pattern  in  16  output of the user-test-pattern FSM.
data_format  in  2  output format: 00 offset binary, 01 two's complement, 10 Gray, 11 treated as offset binary.
out_data  out  DATA_W  formatted, registered sample.
pattern_active  out  1  1 when a test pattern (not adc_data) is driving out_data.

Behaviour:
- Clocking and reset: one clock, synchronous active-high reset.
- Reset values: out_data = 0, pattern_active = 0, mode_q = 4'b0000, generator state = seed (ramp 0, checker/toggle phase 0, LFSRs at their seeds).
- Latency: one clk from any input to out_data and pattern_active.
- Mode decode, raw value in offset binary:
  - 0000: adc_data.
  - 0001: 0x2000 (midscale).
  - 0010: 0x3FFF (+FS).
  - 0011: 0x0000 (-FS).
  - 0100: checkerboard; phase 0 = 0x2AAA, phase 1 = 0x1555.
  - 0101: PN23; polynomial x^23+x^18+1; output lfsr[22:9].
  - 0110: PN9; polynomial x^9+x^5+1; output {lfsr[8:0], lfsr[8:4]}.
  - 0111: one/zero toggle; phase 0 = 0x3FFF, phase 1 = 0x0000.
  - 1000: user_pattern[15:2], MSB-justified.
  - 1111: ramp counter.
  - 1001–1110: treated as 0000 (adc_data), pattern_active = 0.
- LFSR step: shift left by one; new bit0 = XOR of the two tap bits (PN23 taps [22],[17]; PN9 taps [8],[4]).
- Generator advance, per posedge when reset = 0:
  - If select_mode != mode_q: out_data <= fmt(pattern(seed)); state <= next(seed).
  - Else: out_data <= fmt(pattern(state)); state <= next(state).
  - In both cases mode_q <= select_mode.
  - Consequence: the first sample after any mode change is always the seed value, so patterns restart deterministically.
- Ramp: increments by 1 per clk and wraps 0x3FFF -> 0x0000 without stall.
- Checkerboard and toggle: phase flips every clk.
- Only the generator for the selected mode advances; the others hold.
- Formatting applies to all sources:
  - Two's complement: invert the MSB.
  - Gray: g = b ^ (b >> 1), applied to the offset-binary value.
  - A data_format change takes effect on the next sample with no pipeline flush.
- Reset mid-pattern: next output is 0. After reset is released, the first sample is the seed even if select_mode was held constant through reset, because mode_q resets to 0000.
- Exception: a nonzero mode held through reset is treated as a change; a held 0000 passes adc_data directly.
- user_pattern is sampled every clk with no holding; the upstream FSM owns the sequencing.

Decomposition:
- Shared package ad9643_pkg:
  - test-mode enum (4-bit codes above);
  - data-format enum;
  - constants MIDSCALE, POS_FS, NEG_FS, CHECKER_A/B;
  - PN9/PN23 tap constants.
- Sub-module ad9643_lfsr: parameterised width, taps and seed; ports load, advance, state. Instantiated twice (PN9, PN23).

Test Plan:
- Reset for 3 clk with select_mode=0001 -> out_data=0x0000 during reset. Release with data_format=01 -> out_data=0x0000 (midscale 0x2000 with MSB inverted); with data_format=00 -> 0x2000.
- select_mode=1111, data_format=00, run 16386 clk -> out_data 0x0000, 0x0001 … 0x3FFF, then wraps to 0x0000, 0x0001. Switch to 0100 mid-run and back to 1111 -> ramp restarts at 0x0000.
- select_mode=0110 -> first two samples 0x3FFF, then 0x3FDF; pattern_active=1.
- select_mode=1000, user_pattern=0xABCD, data_format=00 -> out_data=0x2AF3 one clk later. With data_format=01 -> 0x0AF3.
- select_mode=0000, adc_data=0x0003, data_format=10 -> out_data=0x0002, pattern_active=0. select_mode=1010 -> same behaviour as 0000.
- select_mode=0111 then 0100 -> 0x3FFF, 0x0000, 0x3FFF …; after the switch, 0x2AAA, 0x1555, 0x2AAA. Assert reset mid-sequence -> 0, then the sequence restarts from seed.
